sram_ctrl_wait: RTL and testbench
=================================

Name: sram_ctrl_wait

Overview:
- Parametrised SRAM access controller between the SLC-3 datapath memory port and the board's asynchronous 16-bit SRAM (pins CE, UB, LB, OE, WE, ADDR, Data).
- Replaces fixed single-cycle strobing with a handshake (req/ready), configurable read and write wait states, byte lanes, and a write-to-read bus turnaround.
- Sits at toplevel beside the CPU. The processor stalls on busy.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, data width; must be 16 (two byte lanes)
READ_WAIT, 2, extra read strobe cycles, 0..15
WRITE_WAIT, 2, extra WE-low cycles, 0..15
TURNAROUND, 1, idle Data-Z cycles after a write before busy drops, 0..7

Ports:
Clk  in  1  system clock, all logic on posedge
Reset  in  1  synchronous, active-low reset
req  in  1  access request, sampled only when busy=0
req_we  in  1  1=write, 0=read
req_be  in  2  byte enables, [1]=upper, [0]=lower
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid while ready=1 after a read
ready  out  1  one-cycle completion pulse
busy  out  1  access in progress
CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
ADDR  out  ADDR_W  SRAM address
Data  inout  DATA_W  SRAM bidirectional bus

Behaviour:
- Reset=0 at posedge: state IDLE; CE=OE=WE=UB=LB=1; ADDR=0; Data=Z; rdata=0; ready=0; busy=0.
- Reset applies mid-access: the access is aborted, strobes are released at the next edge, and no ready is issued.
- Cycle 0 is the cycle in which req=1 and busy=0. The controller latches req_we, req_be, req_addr and req_wdata at the end of cycle 0. busy=1 from cycle 1.
- req is ignored while busy=1. The controller never queues a request.
- States: IDLE, RD_STROBE, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
- Read:
  - RD_STROBE covers cycles 1..READ_WAIT+1. CE=0, OE=0, UB=~be[1], LB=~be[0], ADDR driven, Data=Z.
  - Data is captured into rdata at the end of the last strobe cycle. Disabled bytes are captured as 0x00.
  - RD_DONE is cycle READ_WAIT+2: strobes high, ready=1, busy=0. A new req may be accepted in this cycle.
- Write:
  - WR_SETUP, cycle 1: CE=0, UB/LB per be, ADDR and Data driven, WE=1.
  - WR_PULSE, cycles 2..WRITE_WAIT+2: WE=0.
  - WR_HOLD, cycle WRITE_WAIT+3: WE=1, CE=0, Data still driven, ready=1.
  - TURN follows for TURNAROUND cycles: all strobes high, Data=Z, busy=1. busy drops in the next cycle. With TURNAROUND=0, busy=0 in the cycle after WR_HOLD.
- Bus rule: Data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. OE=0 and Data driven are never true in the same cycle. OE=1 during every write state.
- req_be=00: no-op. No strobes are asserted; ready=1 and busy=0 in cycle 1. rdata is unchanged.
- rdata holds its value until the next read completes. ready is asserted for exactly one cycle per access.
- Address is word-granular. ADDR width follows ADDR_W, with no wrap logic. The controller does not increment ADDR.

Decomposition:
- Shared package sram_pkg holds:
  - typedef enum sram_state_t, covering the 7 states;
  - localparam WAIT_CW = 4 (counter width);
  - localparam BUS_IDLE = 16'hZZZZ.
- One sub-module, sram_wait_counter: synchronous load of N, decrement, done flag, synchronous active-low reset. It is shared by the strobe, pulse and turnaround phases.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with req=1 -> CE=OE=WE=UB=LB=1, Data=Z, busy=0, ready=0 throughout.
- Read: model drives 0xBEEF at ADDR 0x00003; READ_WAIT=2, be=11, read request -> OE=CE=0 in cycles 1-3, ready=1 in cycle 4, rdata=0xBEEF, busy=0 in cycle 4.
- Write: WRITE_WAIT=1, TURNAROUND=1, write 0x1234 to 0x0000A with be=01 -> LB=0, UB=1; WE=0 in cycles 2-3; ready in cycle 4; busy=0 in cycle 6. Read-back with be=11 returns 0xXX34 from the byte-lane model.
- Back-to-back: a second read request held high during cycle 4 of the first read -> accepted in cycle 4, no dead cycle; rdata updates to the second read's data 4 cycles later.
- Abort: Reset=0 in cycle 2 of a write -> WE=1, CE=1 and Data=Z next cycle; no ready; memory model records no write.
- Edge cases:
  - be=00 request: ready in cycle 1, all strobes stay high.
  - req during busy: ignored; exactly one ready per accepted request.
  - Bus contention: assertion checks the bus rule on every cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the wait-state SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_STROBE = 3'd1,
    ST_RD_DONE   = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_PULSE  = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_TURN      = 3'd6
  } sram_state_t;

  localparam int WAIT_CW = 4;
  localparam logic [15:0] BUS_IDLE = 16'hZZZZ;

endpackage

// File: rtl/sram_ctrl_wait_chk.sv
// Bus-ownership assertions for the SRAM controller pins.
module sram_ctrl_wait_chk (
  input logic clk,
  input logic rst_n,
  input logic ce,
  input logic oe,
  input logic we,
  input logic drive
);

  a_no_contention : assert property (@(posedge clk) disable iff (!rst_n) !(drive && !oe));
  a_we_needs_ce   : assert property (@(posedge clk) disable iff (!rst_n) !we |-> !ce);
  a_oe_off_write  : assert property (@(posedge clk) disable iff (!rst_n) (drive || !we) |-> oe);

endmodule

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the read strobe, write pulse and turnaround phases.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int W = WAIT_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_r;

  // load has priority over decrement; the count parks at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/sram_ctrl_wait.sv
// Handshaked asynchronous-SRAM controller with read/write wait states,
// byte lanes and a post-write bus turnaround; all pin outputs are registered.
module sram_ctrl_wait
  import sram_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURNAROUND = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  localparam logic [WAIT_CW-1:0] RD_LOAD   = WAIT_CW'(READ_WAIT);
  localparam logic [WAIT_CW-1:0] WR_LOAD   = WAIT_CW'(WRITE_WAIT);
  localparam logic [WAIT_CW-1:0] TURN_LOAD = (TURNAROUND > 0) ? WAIT_CW'(TURNAROUND - 1) : {WAIT_CW{1'b0}};

  sram_state_t       state_r, nxt_s;
  logic [1:0]        be_r, be_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r, cap_s;
  logic              load_s, capture_s;
  logic              cnt_load_s, cnt_dec_s, cnt_done_s;
  logic [WAIT_CW-1:0] cnt_val_s;
  logic ce_r, oe_r, we_r, ub_r, lb_r, drive_r, ready_r, busy_r;
  logic ce_s, oe_s, we_s, ub_s, lb_s, drive_s, ready_s, busy_s;

  sram_wait_counter #(.W(WAIT_CW)) u_wait (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .done     (cnt_done_s)
  );

  // next-state and phase-counter control; RD_DONE is idle-equivalent and accepts a new request
  always_comb begin
    nxt_s      = state_r;
    load_s     = 1'b0;
    capture_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_val_s  = {WAIT_CW{1'b0}};
    cnt_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_RD_DONE: begin
        if (req) begin
          load_s = 1'b1;
          if (req_be == 2'b00) begin
            nxt_s = ST_RD_DONE;
          end else if (req_we) begin
            nxt_s = ST_WR_SETUP;
          end else begin
            nxt_s      = ST_RD_STROBE;
            cnt_load_s = 1'b1;
            cnt_val_s  = RD_LOAD;
          end
        end else begin
          nxt_s = ST_IDLE;
        end
      end
      ST_RD_STROBE: begin
        if (cnt_done_s) begin
          nxt_s     = ST_RD_DONE;
          capture_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        nxt_s      = ST_WR_PULSE;
        cnt_load_s = 1'b1;
        cnt_val_s  = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_done_s) begin
          nxt_s = ST_WR_HOLD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        if (TURNAROUND > 0) begin
          nxt_s      = ST_TURN;
          cnt_load_s = 1'b1;
          cnt_val_s  = TURN_LOAD;
        end else begin
          nxt_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (cnt_done_s) begin
          nxt_s = ST_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: nxt_s = ST_IDLE;
    endcase
  end

  // pin values for the coming cycle, decoded from the next state
  always_comb begin
    ce_s    = 1'b1;
    oe_s    = 1'b1;
    we_s    = 1'b1;
    drive_s = 1'b0;
    ready_s = 1'b0;
    busy_s  = 1'b1;
    be_s    = load_s ? req_be : be_r;
    case (nxt_s)
      ST_IDLE:      busy_s = 1'b0;
      ST_RD_STROBE: begin ce_s = 1'b0; oe_s = 1'b0; end
      ST_RD_DONE:   begin ready_s = 1'b1; busy_s = 1'b0; end
      ST_WR_SETUP:  begin ce_s = 1'b0; drive_s = 1'b1; end
      ST_WR_PULSE:  begin ce_s = 1'b0; we_s = 1'b0; drive_s = 1'b1; end
      ST_WR_HOLD:   begin ce_s = 1'b0; drive_s = 1'b1; ready_s = 1'b1; end
      ST_TURN:      busy_s = 1'b1;
      default:      busy_s = 1'b0;
    endcase
    ub_s = ce_s | ~be_s[1];
    lb_s = ce_s | ~be_s[0];
  end

  // disabled byte lanes read back as zero
  assign cap_s = {be_r[1] ? Data[15:8] : 8'h00, be_r[0] ? Data[7:0] : 8'h00};

  // state, request latch, read capture and registered pin outputs
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
      be_r    <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      ce_r    <= 1'b1;
      oe_r    <= 1'b1;
      we_r    <= 1'b1;
      ub_r    <= 1'b1;
      lb_r    <= 1'b1;
      drive_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= nxt_s;
      if (load_s) begin
        be_r    <= req_be;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (capture_s) begin
        rdata_r <= cap_s;
      end
      ce_r    <= ce_s;
      oe_r    <= oe_s;
      we_r    <= we_s;
      ub_r    <= ub_s;
      lb_r    <= lb_s;
      drive_r <= drive_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign Data  = drive_r ? wdata_r : BUS_IDLE;
  assign rdata = rdata_r;
  assign ready = ready_r;
  assign busy  = busy_r;
  assign CE    = ce_r;
  assign OE    = oe_r;
  assign WE    = we_r;
  assign UB    = ub_r;
  assign LB    = lb_r;
  assign ADDR  = addr_r;

  sram_ctrl_wait_chk u_chk (
    .clk   (Clk),
    .rst_n (Reset),
    .ce    (ce_r),
    .oe    (oe_r),
    .we    (we_r),
    .drive (drive_r)
  );

endmodule

// File: tb/tb_sram_ctrl_wait.sv
// Directed bench for sram_ctrl_wait with a byte-lane asynchronous SRAM model on the bus.
module tb_sram_ctrl_wait;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req, req_we;
  logic [1:0]  req_be;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rdata;
  logic        ready, busy, CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] data_bus;
  logic [4:0]  strb;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  logic [7:0] mem_hi [0:15];
  logic [7:0] mem_lo [0:15];
  logic       we_prev = 1'b1;

  always #5 Clk = ~Clk;

  sram_ctrl_wait #(
    .ADDR_W(20), .DATA_W(16), .READ_WAIT(2), .WRITE_WAIT(1), .TURNAROUND(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .ready(ready),
    .busy(busy), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR),
    .Data(data_bus)
  );

  assign strb = {CE, OE, WE, UB, LB};
  assign data_bus = (!CE && !OE) ? {mem_hi[ADDR[3:0]], mem_lo[ADDR[3:0]]} : 16'hzzzz;

  // SRAM commits on the WE rising edge only if CE is still low
  always @(negedge Clk) begin
    if (!we_prev && WE && !CE) begin
      if (!UB) mem_hi[ADDR[3:0]] <= data_bus[15:8];
      if (!LB) mem_lo[ADDR[3:0]] <= data_bus[7:0];
      wr_count <= wr_count + 1;
    end
    we_prev <= WE;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; req_we = 1'b0; req_be = 2'b00; req_addr = 20'h0; req_wdata = 16'h0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; req = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 20'h3; req_wdata = 16'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (strb !== 5'b11111) begin n_bad++; $display("FAIL reset_strobes c%0d: got %b want 11111", c, strb); end
      n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL reset_hs c%0d: busy=%b ready=%b want 0 0", c, busy, ready); end
      // a two-state simulator resolves an undriven bus to 0
      n_cmp++; if (data_bus !== 16'hzzzz && data_bus !== 16'h0000) begin n_bad++; $display("FAIL reset_bus c%0d: got %h want z", c, data_bus); end
      n_cmp++; if (rdata !== 16'h0000 || ADDR !== 20'h0) begin n_bad++; $display("FAIL reset_regs c%0d: rdata=%h addr=%h want 0 0", c, rdata, ADDR); end
    end
    Reset = 1'b1; idle_inputs();
    tick();
  endtask

  task automatic test_read();
    req = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 20'h3;
    tick(); idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (strb !== 5'b00100) begin n_bad++; $display("FAIL read_strobe c%0d: got %b want 00100", c, strb); end
      n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL read_busy c%0d: busy=%b ready=%b want 1 0", c, busy, ready); end
      n_cmp++; if (ADDR !== 20'h3) begin n_bad++; $display("FAIL read_addr c%0d: got %h want 3", c, ADDR); end
      tick();
    end
    n_cmp++; if (ready !== 1'b1 || busy !== 1'b0 || strb !== 5'b11111) begin n_bad++; $display("FAIL read_done: ready=%b busy=%b strb=%b want 1 0 11111", ready, busy, strb); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_bad++; $display("FAIL read_data: got %h want beef", rdata); end
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL read_pulse: ready=%b want 0", ready); end
  endtask

  task automatic test_write();
    int base;
    base = wr_count;
    req = 1'b1; req_we = 1'b1; req_be = 2'b01; req_addr = 20'hA; req_wdata = 16'h1234;
    tick(); idle_inputs();
    n_cmp++; if (strb !== 5'b01110 || data_bus !== 16'h1234 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_setup: strb=%b bus=%h busy=%b want 01110 1234 1", strb, data_bus, busy); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_cmp++; if (strb !== 5'b01010 || data_bus !== 16'h1234) begin n_bad++; $display("FAIL wr_pulse c%0d: strb=%b bus=%h want 01010 1234", c, strb, data_bus); end
    end
    tick();
    n_cmp++; if (strb !== 5'b01110 || ready !== 1'b1 || busy !== 1'b1 || data_bus !== 16'h1234) begin n_bad++; $display("FAIL wr_hold: strb=%b ready=%b busy=%b bus=%h want 01110 1 1 1234", strb, ready, busy, data_bus); end
    tick();
    n_cmp++; if (strb !== 5'b11111 || ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_turn: strb=%b ready=%b busy=%b want 11111 0 1", strb, ready, busy); end
    n_cmp++; if (data_bus !== 16'hzzzz && data_bus !== 16'h0000) begin n_bad++; $display("FAIL wr_turn_bus: got %h want z", data_bus); end
    tick();
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL wr_end: busy=%b ready=%b want 0 0", busy, ready); end
    n_cmp++; if (wr_count !== base + 1) begin n_bad++; $display("FAIL wr_count: got %0d want %0d", wr_count, base + 1); end
    req = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 20'hA;
    tick(); idle_inputs();
    tick(); tick(); tick();
    n_cmp++; if (ready !== 1'b1 || rdata !== 16'h5634) begin n_bad++; $display("FAIL wr_readback: ready=%b rdata=%h want 1 5634", ready, rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    req = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 20'h3;
    tick(); idle_inputs();
    tick(); tick(); tick();
    n_cmp++; if (ready !== 1'b1 || rdata !== 16'hBEEF) begin n_bad++; $display("FAIL b2b_first: ready=%b rdata=%h want 1 beef", ready, rdata); end
    req = 1'b1; req_be = 2'b11; req_addr = 20'h5;
    tick(); idle_inputs();
    n_cmp++; if (busy !== 1'b1 || strb !== 5'b00100 || ADDR !== 20'h5) begin n_bad++; $display("FAIL b2b_accept: busy=%b strb=%b addr=%h want 1 00100 5", busy, strb, ADDR); end
    tick(); tick();
    n_cmp++; if (rdata !== 16'hBEEF || ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold: rdata=%h ready=%b want beef 0", rdata, ready); end
    tick();
    n_cmp++; if (ready !== 1'b1 || rdata !== 16'hC0DE) begin n_bad++; $display("FAIL b2b_second: ready=%b rdata=%h want 1 c0de", ready, rdata); end
    tick();
  endtask

  task automatic test_noop();
    req = 1'b1; req_we = 1'b0; req_be = 2'b00; req_addr = 20'h3;
    tick(); idle_inputs();
    n_cmp++; if (ready !== 1'b1 || busy !== 1'b0 || strb !== 5'b11111) begin n_bad++; $display("FAIL noop_c1: ready=%b busy=%b strb=%b want 1 0 11111", ready, busy, strb); end
    n_cmp++; if (rdata !== 16'hC0DE) begin n_bad++; $display("FAIL noop_rdata: got %h want c0de", rdata); end
    tick();
    n_cmp++; if (ready !== 1'b0 || strb !== 5'b11111) begin n_bad++; $display("FAIL noop_c2: ready=%b strb=%b want 0 11111", ready, strb); end
  endtask

  task automatic test_req_busy();
    int base;
    int rdy;
    base = wr_count; rdy = 0;
    req = 1'b1; req_we = 1'b1; req_be = 2'b11; req_addr = 20'h7; req_wdata = 16'hA5A5;
    tick();
    req_we = 1'b0; req_addr = 20'h8;
    for (int c = 1; c <= 10; c++) begin
      if (c == 6) idle_inputs();
      if (ready === 1'b1) rdy++;
      if (c == 3) begin
        n_cmp++; if (ADDR !== 20'h7) begin n_bad++; $display("FAIL busy_addr: got %h want 7", ADDR); end
      end
      tick();
    end
    n_cmp++; if (rdy !== 1) begin n_bad++; $display("FAIL busy_ready_count: got %0d want 1", rdy); end
    n_cmp++; if (wr_count !== base + 1 || mem_hi[7] !== 8'hA5 || mem_lo[7] !== 8'hA5) begin n_bad++; $display("FAIL busy_write: count=%0d mem=%h%h want %0d a5a5", wr_count, mem_hi[7], mem_lo[7], base + 1); end
  endtask

  task automatic test_abort();
    int base;
    base = wr_count;
    req = 1'b1; req_we = 1'b1; req_be = 2'b11; req_addr = 20'h9; req_wdata = 16'hFFFF;
    tick(); idle_inputs();
    tick();
    n_cmp++; if (strb !== 5'b01000) begin n_bad++; $display("FAIL abort_pulse: strb=%b want 01000", strb); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    n_cmp++; if (strb !== 5'b11111 || busy !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL abort_release: strb=%b busy=%b ready=%b want 11111 0 0", strb, busy, ready); end
    n_cmp++; if (data_bus !== 16'hzzzz && data_bus !== 16'h0000) begin n_bad++; $display("FAIL abort_bus: got %h want z", data_bus); end
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL abort_rdata: got %h want 0", rdata); end
    for (int c = 4; c <= 6; c++) begin
      tick();
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_noready c%0d: ready=%b want 0", c, ready); end
    end
    n_cmp++; if (wr_count !== base || mem_hi[9] !== 8'h11 || mem_lo[9] !== 8'h22) begin n_bad++; $display("FAIL abort_nowrite: count=%0d mem=%h%h want %0d 1122", wr_count, mem_hi[9], mem_lo[9], base); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_hi[i] = 8'h00;
      mem_lo[i] = 8'h00;
    end
    mem_hi[3] = 8'hBE; mem_lo[3] = 8'hEF;
    mem_hi[5] = 8'hC0; mem_lo[5] = 8'hDE;
    mem_hi[9] = 8'h11; mem_lo[9] = 8'h22;
    mem_hi[10] = 8'h56; mem_lo[10] = 8'h00;
    idle_inputs();
    Reset = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_noop();
    test_req_busy();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
